// File: rtl/rv32_div_seq_pkg.sv
// Shared types and constants for the RV32M sequential divider and its ALU slot.
package rv32_div_seq_pkg;

  typedef logic [31:0] rv32_word;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_SLL  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_SLT  = 4'd8,
    ALU_OP_SLTU = 4'd9
  } int_alu_op_t;

  localparam rv32_word RV32_INT_MIN   = 32'h8000_0000;
  localparam int       RV32_DIV_ITERS = 32;

  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/rv32_div_seq_if.sv
// Request/response handshake plus shared-ALU slot between the exec stage and the divider.
interface rv32_div_seq_if;
  import rv32_div_seq_pkg::*;

  logic        kill;
  logic        req_valid;
  logic        req_ready;
  div_op_t     req_op;
  rv32_word    req_a;
  rv32_word    req_b;
  logic        resp_valid;
  logic        resp_ready;
  rv32_word    resp_result;
  logic        alu_req;
  logic        alu_gnt;
  rv32_word    alu_op1;
  rv32_word    alu_op2;
  int_alu_op_t alu_opsel;
  rv32_word    alu_result;

  modport master (
    output kill, req_valid, req_op, req_a, req_b, resp_ready, alu_gnt, alu_result,
    input  req_ready, resp_valid, resp_result, alu_req, alu_op1, alu_op2, alu_opsel
  );

  modport slave (
    input  kill, req_valid, req_op, req_a, req_b, resp_ready, alu_gnt, alu_result,
    output req_ready, resp_valid, resp_result, alu_req, alu_op1, alu_op2, alu_opsel
  );

endinterface

// File: rtl/rv32_div_seq.sv
// Restoring divider for DIV/DIVU/REM/REMU that borrows the exec-stage ALU for every
// subtraction; it freezes completely on any cycle where the ALU slot is not granted.
module rv32_div_seq
  import rv32_div_seq_pkg::*;
#(
  parameter bit FAST_SPECIAL = 1'b1
) (
  input logic          clk,
  input logic          rst,
  rv32_div_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SPECIAL, NEG_A, NEG_B, ITER, POST, DONE
  } div_state_t;

  localparam logic [4:0] LAST_ITER = 5'(RV32_DIV_ITERS - 1);

  div_state_t state_q, state_d;
  div_op_t    op_q, op_d;
  rv32_word   a_q, a_d;
  rv32_word   b_q, b_d;
  rv32_word   quo_q, quo_d;
  rv32_word   rem_q, rem_d;
  rv32_word   res_q, res_d;
  logic       sa_q, sa_d;
  logic       sb_q, sb_d;
  logic [4:0] cnt_q, cnt_d;

  logic [32:0] shifted;
  logic        take;
  rv32_word    iter_quo;
  rv32_word    iter_rem;
  rv32_word    fix_x;
  logic        fix_neg;
  logic        req_signed;
  logic        req_special;

  // a_q is shifted left each iteration, so its MSB is always the next dividend bit.
  assign shifted  = {rem_q, a_q[31]};
  assign take     = shifted[32] || (shifted[31:0] >= b_q);
  assign iter_quo = {quo_q[30:0], take};
  assign iter_rem = take ? bus.alu_result : shifted[31:0];

  // A zero divisor must leave the all-ones quotient un-negated to match RISC-V.
  assign fix_x   = op_is_rem(op_q) ? rem_q : quo_q;
  assign fix_neg = op_is_rem(op_q) ? sa_q : ((sa_q ^ sb_q) && (b_q != '0));

  assign req_signed  = op_is_signed(bus.req_op);
  assign req_special = FAST_SPECIAL &&
                       ((bus.req_b == '0) ||
                        (req_signed && (bus.req_a == RV32_INT_MIN) && (bus.req_b == '1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= DIV;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    res_d   = res_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && !bus.kill) begin
          op_d  = bus.req_op;
          a_d   = bus.req_a;
          b_d   = bus.req_b;
          sa_d  = req_signed && bus.req_a[31];
          sb_d  = req_signed && bus.req_b[31];
          quo_d = '0;
          rem_d = '0;
          cnt_d = '0;
          if (req_special)     state_d = SPECIAL;
          else if (req_signed) state_d = NEG_A;
          else                 state_d = ITER;
        end
      end
      SPECIAL: begin
        if (b_q == '0) res_d = op_is_rem(op_q) ? a_q : '1;
        else           res_d = op_is_rem(op_q) ? '0 : RV32_INT_MIN;
        state_d = DONE;
      end
      NEG_A: begin
        if (bus.alu_gnt) begin
          if (sa_q) a_d = bus.alu_result;
          state_d = NEG_B;
        end
      end
      NEG_B: begin
        if (bus.alu_gnt) begin
          if (sb_q) b_d = bus.alu_result;
          state_d = ITER;
        end
      end
      ITER: begin
        if (bus.alu_gnt) begin
          quo_d = iter_quo;
          rem_d = iter_rem;
          a_d   = {a_q[30:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            res_d   = op_is_rem(op_q) ? iter_rem : iter_quo;
            state_d = op_is_signed(op_q) ? POST : DONE;
          end
        end
      end
      POST: begin
        if (bus.alu_gnt) begin
          res_d   = fix_neg ? bus.alu_result : fix_x;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.kill) state_d = IDLE;
  end

  // ALU operands depend only on registered state, so they hold while the slot is denied.
  always_comb begin
    bus.req_ready   = (state_q == IDLE);
    bus.resp_valid  = (state_q == DONE);
    bus.resp_result = (state_q == DONE) ? res_q : '0;
    bus.alu_req     = 1'b0;
    bus.alu_opsel   = ALU_OP_ADD;
    bus.alu_op1     = '0;
    bus.alu_op2     = '0;

    unique case (state_q)
      NEG_A: begin
        bus.alu_req   = 1'b1;
        bus.alu_opsel = ALU_OP_SUB;
        bus.alu_op2   = a_q;
      end
      NEG_B: begin
        bus.alu_req   = 1'b1;
        bus.alu_opsel = ALU_OP_SUB;
        bus.alu_op2   = b_q;
      end
      ITER: begin
        bus.alu_req   = 1'b1;
        bus.alu_opsel = ALU_OP_SUB;
        bus.alu_op1   = shifted[31:0];
        bus.alu_op2   = b_q;
      end
      POST: begin
        bus.alu_req   = 1'b1;
        bus.alu_opsel = ALU_OP_SUB;
        bus.alu_op2   = fix_x;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32_div_seq.sv
// Runs FAST_SPECIAL=1 and FAST_SPECIAL=0 dividers side by side on identical stimulus.
module tb_rv32_div_seq;
  import rv32_div_seq_pkg::*;

  localparam int MAXC = 100;

  logic     clk = 1'b0;
  logic     rst;
  logic     kill;
  logic     req_valid;
  logic     resp_ready;
  logic     alu_gnt;
  div_op_t  req_op;
  rv32_word req_a;
  rv32_word req_b;

  int   checks = 0;
  int   errors = 0;
  logic deny [0:127];

  always #5 clk = ~clk;

  rv32_div_seq_if bus1 ();
  rv32_div_seq_if bus0 ();

  assign bus1.kill       = kill;
  assign bus1.req_valid  = req_valid;
  assign bus1.req_op     = req_op;
  assign bus1.req_a      = req_a;
  assign bus1.req_b      = req_b;
  assign bus1.resp_ready = resp_ready;
  assign bus1.alu_gnt    = alu_gnt;
  assign bus1.alu_result = (bus1.alu_opsel == ALU_OP_SUB) ? bus1.alu_op1 - bus1.alu_op2
                                                          : bus1.alu_op1 + bus1.alu_op2;
  assign bus0.kill       = kill;
  assign bus0.req_valid  = req_valid;
  assign bus0.req_op     = req_op;
  assign bus0.req_a      = req_a;
  assign bus0.req_b      = req_b;
  assign bus0.resp_ready = resp_ready;
  assign bus0.alu_gnt    = alu_gnt;
  assign bus0.alu_result = (bus0.alu_opsel == ALU_OP_SUB) ? bus0.alu_op1 - bus0.alu_op2
                                                          : bus0.alu_op1 + bus0.alu_op2;

  rv32_div_seq #(.FAST_SPECIAL(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  rv32_div_seq #(.FAST_SPECIAL(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    div_op_t  op;
    rv32_word a;
    rv32_word b;
    rv32_word exp;
    int       lat1;
    int       lat0;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic rv32_word ref_div(input div_op_t op, input rv32_word a, input rv32_word b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REMU:    return (b == 0) ? a : a % b;
      DIV:     return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      default: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
    endcase
  endfunction

  task automatic hold_check(input string tag, input logic pr, input rv32_word pa,
                            input rv32_word pb, input rv32_word ca, input rv32_word cb,
                            input int_alu_op_t cs);
    if (!alu_gnt && pr) begin
      check({tag, "_op1_hold"}, ca, pa);
      check({tag, "_op2_hold"}, cb, pb);
      check({tag, "_opsel_sub"}, 32'(cs), 32'(ALU_OP_SUB));
    end
  endtask

  // Issues one request to both DUTs (resp_ready=1) and returns results and latencies.
  task automatic run_op(input div_op_t op, input rv32_word a, input rv32_word b,
                        output rv32_word r1, output rv32_word r0,
                        output int l1, output int l0);
    rv32_word p1a, p1b, p0a, p0b;
    logic pr1, pr0;
    r1 = '0; r0 = '0; l1 = -1; l0 = -1;
    p1a = '0; p1b = '0; p0a = '0; p0b = '0; pr1 = 1'b0; pr0 = 1'b0;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; resp_ready = 1'b1; alu_gnt = 1'b1;
    for (int k = 1; k <= MAXC && (l1 < 0 || l0 < 0); k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      hold_check("dut1", pr1, p1a, p1b, bus1.alu_op1, bus1.alu_op2, bus1.alu_opsel);
      hold_check("dut0", pr0, p0a, p0b, bus0.alu_op1, bus0.alu_op2, bus0.alu_opsel);
      if (bus1.resp_valid && l1 < 0) begin r1 = bus1.resp_result; l1 = k; end
      if (bus0.resp_valid && l0 < 0) begin r0 = bus0.resp_result; l0 = k; end
      pr1 = bus1.alu_req; p1a = bus1.alu_op1; p1b = bus1.alu_op2;
      pr0 = bus0.alu_req; p0a = bus0.alu_op1; p0b = bus0.alu_op2;
      alu_gnt = !deny[k];
    end
    alu_gnt = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready1"}, 32'(bus1.req_ready), 32'd1);
    check({tag, "_resp_valid1"}, 32'(bus1.resp_valid), 32'd0);
    check({tag, "_alu_req1"}, 32'(bus1.alu_req), 32'd0);
    check({tag, "_resp_result1"}, bus1.resp_result, 32'd0);
    check({tag, "_req_ready0"}, 32'(bus0.req_ready), 32'd1);
    check({tag, "_resp_valid0"}, 32'(bus0.resp_valid), 32'd0);
    check({tag, "_alu_req0"}, 32'(bus0.alu_req), 32'd0);
    check({tag, "_resp_result0"}, bus0.resp_result, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rv32_word r1, r0, e;
    int l1, l0, n, k, tmp, mode;
    div_op_t op;
    rv32_word a, b;
    logic saw1, saw0;

    vecs.push_back('{DIVU, 32'd100,        32'd7,          32'd14,         33, 33});
    vecs.push_back('{REMU, 32'd100,        32'd7,          32'd2,          33, 33});
    vecs.push_back('{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  36, 36});
    vecs.push_back('{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  36, 36});
    vecs.push_back('{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  36, 36});
    vecs.push_back('{REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          36, 36});
    vecs.push_back('{DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          36, 36});
    vecs.push_back('{REM,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  36, 36});
    vecs.push_back('{DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,   2, 36});
    vecs.push_back('{REMU, 32'd5,          32'd0,          32'd5,           2, 33});
    vecs.push_back('{DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,   2, 33});
    vecs.push_back('{DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,   2, 36});
    vecs.push_back('{REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,   2, 36});
    vecs.push_back('{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   2, 36});
    vecs.push_back('{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,           2, 36});
    vecs.push_back('{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 33});
    vecs.push_back('{REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33, 33});
    vecs.push_back('{DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  36, 36});
    vecs.push_back('{DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          33, 33});
    vecs.push_back('{DIVU, 32'd0,          32'd5,          32'd0,          33, 33});

    for (int i = 0; i < 128; i++) deny[i] = 1'b0;
    rst = 1'b1; kill = 1'b0; req_valid = 1'b0; resp_ready = 1'b1; alu_gnt = 1'b1;
    req_op = DIVU; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r1, r0, l1, l0);
      check($sformatf("vec%0d_result_fast", i), r1, vecs[i].exp);
      check($sformatf("vec%0d_result_slow", i), r0, vecs[i].exp);
      check($sformatf("vec%0d_latency_fast", i), 32'(l1), 32'(vecs[i].lat1));
      check($sformatf("vec%0d_latency_slow", i), 32'(l0), 32'(vecs[i].lat0));
    end

    // Ten denied grants scattered through the iteration phase.
    n = 0;
    while (n < 10) begin
      k = int'($urandom_range(1, 30));
      if (!deny[k]) begin deny[k] = 1'b1; n++; end
    end
    run_op(DIVU, 32'hFFFF_FFFF, 32'd1, r1, r0, l1, l0);
    check("deny_result_fast", r1, 32'hFFFF_FFFF);
    check("deny_result_slow", r0, 32'hFFFF_FFFF);
    check("deny_latency_fast", 32'(l1), 32'd43);
    check("deny_latency_slow", 32'(l0), 32'd43);
    for (int i = 0; i < 128; i++) deny[i] = 1'b0;

    // Kill while cnt==15 (cycle 16 after accept).
    req_op = DIVU; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1; resp_ready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_idle_fast", 32'(bus1.req_ready), 32'd1);
    check("kill_idle_slow", 32'(bus0.req_ready), 32'd1);
    check("kill_noresp_fast", 32'(bus1.resp_valid), 32'd0);
    check("kill_noresp_slow", 32'(bus0.resp_valid), 32'd0);
    saw1 = 1'b0; saw0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      saw1 = saw1 | bus1.resp_valid;
      saw0 = saw0 | bus0.resp_valid;
    end
    check("kill_quiet_fast", 32'(saw1), 32'd0);
    check("kill_quiet_slow", 32'(saw0), 32'd0);

    // Follow-up DIVU 9/3 with the response held off for five cycles.
    req_op = DIVU; req_a = 32'd9; req_b = 32'd3; req_valid = 1'b1; resp_ready = 1'b0;
    l1 = -1; l0 = -1;
    for (int c = 1; c <= MAXC && (l1 < 0 || l0 < 0); c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (bus1.resp_valid && l1 < 0) l1 = c;
      if (bus0.resp_valid && l0 < 0) l0 = c;
    end
    check("hold_latency_fast", 32'(l1), 32'd33);
    check("hold_latency_slow", 32'(l0), 32'd33);
    req_valid = 1'b1;
    req_a = 32'd50;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_result_fast", bus1.resp_result, 32'd3);
      check("hold_valid_fast", 32'(bus1.resp_valid), 32'd1);
      check("hold_ready_fast", 32'(bus1.req_ready), 32'd0);
      check("hold_result_slow", bus0.resp_result, 32'd3);
      check("hold_ready_slow", 32'(bus0.req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("release_valid_fast", 32'(bus1.resp_valid), 32'd0);
    check("release_ready_fast", 32'(bus1.req_ready), 32'd1);
    check("release_ready_slow", 32'(bus0.req_ready), 32'd1);

    // Reset in the middle of the iteration phase.
    req_op = DIV; req_a = 32'hFFFF_0000; req_b = 32'd7; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_op1_fast", bus1.alu_op1, 32'd0);
    check("midrst_op2_fast", bus1.alu_op2, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Random operations against the reference model, with random grant denial.
    for (int t = 0; t < 40; t++) begin
      op = div_op_t'(2'($urandom_range(0, 3)));
      mode = int'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (mode == 1) begin
        tmp = int'($urandom_range(0, 40)) - 20; a = 32'(tmp);
        tmp = int'($urandom_range(0, 40)) - 20; b = 32'(tmp);
      end else if (mode == 2) begin
        b = '0;
      end else if (mode == 3 && $urandom_range(0, 1) == 1) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
      for (int i = 1; i < 128; i++) deny[i] = ($urandom_range(0, 3) == 0);
      e = ref_div(op, a, b);
      run_op(op, a, b, r1, r0, l1, l0);
      check($sformatf("rand%0d_op%0d_a%h_b%h_fast", t, op, a, b), r1, e);
      check($sformatf("rand%0d_op%0d_a%h_b%h_slow", t, op, a, b), r0, e);
    end
    for (int i = 0; i < 128; i++) deny[i] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
